// File: rtl/debounce_pkg.sv
// Shared types and default timing constants for the key debouncer.
// Counter widths are sized with the countWidth helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_REPEAT_DELAY    = 25000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 5000000;

    function automatic int countWidth(input int maxValue);
        return (maxValue < 1) ? 1 : $clog2(maxValue + 1);
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// Up-counter with synchronous clear (priority over enable) and a flag that is
// high when the next enabled cycle would reach TERMINAL.
module cycle_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == WIDTH'(TERMINAL - 1));

endmodule

// File: rtl/debounce_edge.sv
// Debounces a synchronized key level into a clean level plus press/release strobes.
// Define DEBOUNCE_AUTOREPEAT_EN to add auto-repeat press strobes while the key is held.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int DEB_W = countWidth(DEBOUNCE_CYCLES);

    state_t state_q, state_d;
    logic level_q, level_d;
    logic press_q, release_q;
    logic risePress_d, release_d, repPress;
    logic debClear, debEnable, debLast;
    logic [DEB_W-1:0] debCount_unused;

    cycle_counter #(.WIDTH(DEB_W), .TERMINAL(DEBOUNCE_CYCLES)) debCounter (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (debClear),
        .enable_i (debEnable),
        .count_o  (debCount_unused),
        .last_o   (debLast)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= risePress_d | repPress;
            release_q <= release_d;
        end
    end

    // The counter holds matches already seen, so debLast means this sample is the final one.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        risePress_d = 1'b0;
        release_d   = 1'b0;
        debClear    = 1'b0;
        debEnable   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_i) begin
                    state_d   = RISE_WAIT;
                    debEnable = 1'b1;
                end
            end
            RISE_WAIT: begin
                if (!in_i) begin
                    state_d  = IDLE;
                    debClear = 1'b1;
                end else if (debLast) begin
                    state_d     = HIGH;
                    level_d     = 1'b1;
                    risePress_d = 1'b1;
                    debClear    = 1'b1;
                end else begin
                    debEnable = 1'b1;
                end
            end
            HIGH: begin
                if (!in_i) begin
                    state_d   = FALL_WAIT;
                    debEnable = 1'b1;
                end
            end
            FALL_WAIT: begin
                if (in_i) begin
                    state_d  = HIGH;
                    debClear = 1'b1;
                end else if (debLast) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    debClear  = 1'b1;
                end else begin
                    debEnable = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                level_d  = 1'b0;
                debClear = 1'b1;
            end
        endcase
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = countWidth(REP_MAX);

    logic             repClear, repEnable, repDelayLast, repHit;
    logic             repeating_q, repeating_d;
    logic [REP_W-1:0] repCount;

    cycle_counter #(.WIDTH(REP_W), .TERMINAL(REPEAT_DELAY)) repCounter (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (repClear),
        .enable_i (repEnable),
        .count_o  (repCount),
        .last_o   (repDelayLast)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            repeating_q <= 1'b0;
        end else begin
            repeating_q <= repeating_d;
        end
    end

    assign repHit = repeating_q ? (repCount == REP_W'(REPEAT_PERIOD - 1)) : repDelayLast;

    // Only counts while staying in HIGH; any exit or fresh entry restarts from the initial delay.
    always_comb begin
        repClear    = 1'b1;
        repEnable   = 1'b0;
        repPress    = 1'b0;
        repeating_d = 1'b0;
        if (state_q == HIGH && in_i) begin
            repClear    = 1'b0;
            repeating_d = repeating_q;
            if (repHit) begin
                repPress    = 1'b1;
                repClear    = 1'b1;
                repeating_d = 1'b1;
            end else begin
                repEnable = 1'b1;
            end
        end
    end
`else
    localparam int repeatParams_unused = REPEAT_DELAY + REPEAT_PERIOD;
    assign repPress = 1'b0;
`endif

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule
